// File: rtl/down_count_monitor_if.sv
// Count-bus monitor link: upstream count value and clear in, lock/wrap/error status out.
// The master drives the counter side; the slave is the monitor itself.
interface down_count_monitor_if #(
    parameter int CNT_W  = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
) ();
    logic [CNT_W-1:0]  count_in;
    logic              clr;
    logic              locked;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wraps;
    logic              err_flag;
    logic [ERR_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  last_err_val;

    modport master (
        output count_in, clr,
        input  locked, wrap_pulse, wraps, err_flag, err_cnt, last_err_val
    );

    modport slave (
        input  count_in, clr,
        output locked, wrap_pulse, wraps, err_flag, err_cnt, last_err_val
    );
endinterface

// File: rtl/down_count_monitor.sv
// Down-counter sequence checker: locks on prev-1 runs, pulses on 0->all-ones wraps, counts errors.
// Latency one cycle (all outputs registered); no backpressure, samples count_in every cycle.
module down_count_monitor #(
    parameter int CNT_W    = 4,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4,
    parameter int LOCK_CNT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    down_count_monitor_if.slave  mon
);
    typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED, ERROR} state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  prev_q;
    logic [3:0]        run_q, run_d;
    logic              locked_q;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              err_flag_q, err_flag_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  last_err_q, last_err_d;

    logic [CNT_W-1:0]  expected;
    logic              match;

    assign expected = prev_q - CNT_W'(1);
    assign match    = (mon.count_in == expected);

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        wrap_pulse_d = 1'b0;
        wraps_d      = wraps_q;
        err_flag_d   = err_flag_q;
        err_cnt_d    = err_cnt_q;
        last_err_d   = last_err_q;
        case (state_q)
            UNLOCKED: begin
                run_d   = '0;
                state_d = CHECK;
            end
            CHECK: begin
                if (match) begin
                    run_d = run_q + 4'd1;
                    if (run_q + 4'd1 == LOCK_RUN) state_d = LOCKED;
                end else begin
                    run_d = '0;
                end
            end
            LOCKED: begin
                if (match) begin
                    // Wrap is the 0 -> all-ones step of a locked sequence.
                    if (prev_q == '0) begin
                        wrap_pulse_d = 1'b1;
                        if (wraps_q != '1) wraps_d = wraps_q + WRAP_W'(1);
                    end
                end else begin
                    state_d    = ERROR;
                    err_flag_d = 1'b1;
                    last_err_d = mon.count_in;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end
            ERROR: begin
                run_d   = match ? 4'd1 : 4'd0;
                state_d = (match && LOCK_CNT == 1) ? LOCKED : CHECK;
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || mon.clr) begin
            state_q      <= UNLOCKED;
            prev_q       <= '0;
            run_q        <= '0;
            locked_q     <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wraps_q      <= '0;
            err_flag_q   <= 1'b0;
            err_cnt_q    <= '0;
            last_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= mon.count_in;
            run_q        <= run_d;
            locked_q     <= (state_d == LOCKED);
            wrap_pulse_q <= wrap_pulse_d;
            wraps_q      <= wraps_d;
            err_flag_q   <= err_flag_d;
            err_cnt_q    <= err_cnt_d;
            last_err_q   <= last_err_d;
        end
    end

    assign mon.locked       = locked_q;
    assign mon.wrap_pulse   = wrap_pulse_q;
    assign mon.wraps        = wraps_q;
    assign mon.err_flag     = err_flag_q;
    assign mon.err_cnt      = err_cnt_q;
    assign mon.last_err_val = last_err_q;
endmodule

// File: tb/tb_down_count_monitor.sv
// Bench for down_count_monitor: directed plan steps then random traffic against a reference model.
// A second instance with 2-bit wrap/error counters exercises saturation on the same stimulus.
module tb_down_count_monitor;
    localparam int LOCK = 3;

    logic clk;
    logic rst;

    down_count_monitor_if #(.CNT_W(4), .WRAP_W(8), .ERR_W(4)) dif ();
    down_count_monitor_if #(.CNT_W(4), .WRAP_W(2), .ERR_W(2)) sif ();

    down_count_monitor #(.CNT_W(4), .WRAP_W(8), .ERR_W(4), .LOCK_CNT(LOCK)) dut (
        .clk(clk), .rst(rst), .mon(dif.slave)
    );
    down_count_monitor #(.CNT_W(4), .WRAP_W(2), .ERR_W(2), .LOCK_CNT(LOCK)) dut_s (
        .clk(clk), .rst(rst), .mon(sif.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int c        = 0;

    // Reference model: counts kept unbounded, saturation applied when compared.
    bit m_primed, m_locked, m_errcyc, m_wrap, m_errf;
    int m_run, m_prev, m_wraps, m_errs, m_lastv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_edge(input bit r, input bit cl, input int cin);
        bit match;
        match  = (cin == ((m_prev + 15) % 16));
        m_wrap = 0;
        if (!r || cl) begin
            m_primed = 0; m_locked = 0; m_errcyc = 0; m_errf = 0;
            m_run = 0; m_prev = 0; m_wraps = 0; m_errs = 0; m_lastv = 0;
        end else begin
            if (!m_primed) begin
                m_primed = 1;
                m_run    = 0;
            end else if (m_errcyc) begin
                m_errcyc = 0;
                m_run    = match ? 1 : 0;
                m_locked = match && (LOCK == 1);
            end else if (m_locked) begin
                if (match) begin
                    if (m_prev == 0) begin
                        m_wrap = 1;
                        m_wraps++;
                    end
                end else begin
                    m_locked = 0; m_errcyc = 1; m_errf = 1;
                    m_errs++;
                    m_lastv = cin;
                end
            end else begin
                if (match) begin
                    m_run++;
                    if (m_run == LOCK) m_locked = 1;
                end else begin
                    m_run = 0;
                end
            end
            m_prev = cin;
        end
    endtask

    task automatic check_model();
        chk("locked",        dif.locked,       m_locked);
        chk("wrap_pulse",    dif.wrap_pulse,   m_wrap);
        chk("wraps",         dif.wraps,        sat(m_wraps, 255));
        chk("err_flag",      dif.err_flag,     m_errf);
        chk("err_cnt",       dif.err_cnt,      sat(m_errs, 15));
        chk("last_err_val",  dif.last_err_val, m_lastv);
        chk("s_locked",      sif.locked,       m_locked);
        chk("s_wrap_pulse",  sif.wrap_pulse,   m_wrap);
        chk("s_wraps",       sif.wraps,        sat(m_wraps, 3));
        chk("s_err_cnt",     sif.err_cnt,      sat(m_errs, 3));
    endtask

    task automatic step(input bit r, input bit cl, input int cin);
        rst          = r;
        dif.clr      = cl;
        sif.clr      = cl;
        dif.count_in = 4'(cin);
        sif.count_in = 4'(cin);
        @(posedge clk);
        model_edge(r, cl, cin);
        c = cin;
        #1;
        check_model();
    endtask

    task automatic count_down(input int n);
        for (int i = 0; i < n; i++) step(1, 0, (c + 15) % 16);
    endtask

    initial begin
        clk = 0; rst = 0;
        dif.clr = 0; sif.clr = 0; dif.count_in = '0; sif.count_in = '0;
        m_prev = 0;

        // Reset then lock on 15,14,13,12
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_wraps", dif.wraps, 0);
        chk("rst_last", dif.last_err_val, 0);
        step(1, 0, 15); chk("lk15", dif.locked, 0);
        step(1, 0, 14); chk("lk14", dif.locked, 0);
        step(1, 0, 13); chk("lk13", dif.locked, 0);
        step(1, 0, 12); chk("lk12", dif.locked, 1);
        chk("lk12_err", dif.err_flag, 0);

        // First wrap, then a second full period
        count_down(13);
        chk("wrap1_pulse", dif.wrap_pulse, 1);
        chk("wrap1_cnt", dif.wraps, 1);
        count_down(1);
        chk("wrap1_end", dif.wrap_pulse, 0);
        count_down(15);
        chk("wrap2_cnt", dif.wraps, 2);

        // Glitch 7,6,9 then recover on 8,7,6
        count_down(9);
        step(1, 0, 9);
        chk("gl_flag", dif.err_flag, 1);
        chk("gl_cnt", dif.err_cnt, 1);
        chk("gl_val", dif.last_err_val, 9);
        chk("gl_lock", dif.locked, 0);
        count_down(2);
        chk("gl_relock7", dif.locked, 0);
        count_down(1);
        chk("gl_relock6", dif.locked, 1);
        chk("gl_sticky", dif.err_flag, 1);

        // Saturation of the narrow counters
        count_down(80);
        chk("sat_wraps_s", sif.wraps, 3);
        chk("sat_wraps", dif.wraps, 7);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, (c + 5) % 16);
            chk("sat_err", dif.err_cnt, i + 2);
            chk("sat_err_s", sif.err_cnt, (i + 2 > 3) ? 3 : i + 2);
            count_down(3);
        end

        // clr mid-run
        step(1, 1, 3);
        chk("clr_lock", dif.locked, 0);
        chk("clr_wraps", dif.wraps, 0);
        chk("clr_err", dif.err_flag, 0);
        chk("clr_cnt", dif.err_cnt, 0);
        step(1, 0, 15); step(1, 0, 14); step(1, 0, 13);
        chk("clr_lk13", dif.locked, 0);
        step(1, 0, 12);
        chk("clr_lk12", dif.locked, 1);

        // rst over clr, then stuck input while locked
        step(0, 1, 7);
        chk("pri_wraps", dif.wraps, 0);
        step(1, 0, 9);
        count_down(5);
        chk("stk_lock", dif.locked, 1);
        step(1, 0, 4);
        chk("stk_flag", dif.err_flag, 1);
        chk("stk_val", dif.last_err_val, 4);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)       step(1, 1, $urandom_range(0, 15));
            else if (r == 3) step(0, 0, $urandom_range(0, 15));
            else if (r < 12) step(1, 0, $urandom_range(0, 15));
            else             step(1, 0, (c + 15) % 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
Downstream checker/consumer for the free-running synchronous 4-bit down counter. It samples the counter's count bus every clock and checks that each value is exactly previous-1 (mod 2^CNT_W). It locks onto a valid sequence, emits a one-cycle pulse on every 0 -> all-ones wrap, and accumulates a saturating wrap count. Sequence breaks raise a sticky error, are counted, and force re-acquisition. Used as an on-chip health monitor and as the period tick source for slower logic.

Parameters:
CNT_W, 4, width of monitored count bus
WRAP_W, 8, width of wrap counter
ERR_W, 4, width of error counter
LOCK_CNT, 3, consecutive correct decrements required to enter LOCKED (legal range 1..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low
count_in  input  CNT_W  count value from upstream down counter
clr  input  1  synchronous clear, active-high, same effect as reset
locked  output  1  high while FSM is in LOCKED
wrap_pulse  output  1  one-cycle pulse per detected wrap while locked
wraps  output  WRAP_W  number of wraps seen while locked, saturating
err_flag  output  1  sticky, set on any mismatch while LOCKED
err_cnt  output  ERR_W  number of LOCKED mismatches, saturating
last_err_val  output  CNT_W  count_in value that caused the most recent error

Behaviour:
- All outputs are registered; no combinational path from count_in to any output.
- Reset: rst==0 at a rising edge forces state=UNLOCKED, prev=0, run=0, locked=0, wrap_pulse=0, wraps=0, err_flag=0, err_cnt=0, last_err_val=0. rst has priority over clr; clr==1 (with rst==1) has an identical effect. Both take effect mid-operation at the next edge.
- Internals: prev holds the count_in sampled at the previous edge. expected = prev-1 truncated to CNT_W (0 -> 2^CNT_W-1). match = (count_in==expected). run = 4-bit consecutive-match counter.
- FSM, evaluated at each edge (rst==1, clr==0):
  UNLOCKED: prev<=count_in, run<=0, go to CHECK. There is no comparison in this state.
  CHECK: if match, run<=run+1, and go to LOCKED when run+1==LOCK_CNT; else run<=0 and stay in CHECK.
  LOCKED: if match, stay. If mismatch, go to ERROR, set err_flag<=1, last_err_val<=count_in, and increment err_cnt (saturating at all-ones).
  ERROR: lasts exactly one cycle, then go to CHECK with run<=1 if match, else run<=0. If LOCK_CNT==1 and match, go directly to LOCKED.
  prev<=count_in at every edge in every state.
- locked<=1 exactly when the next state is LOCKED.
- Wrap: detected when the current state is LOCKED, match is true, and prev==0.
  - On a wrap, wrap_pulse<=1 for that single cycle, otherwise 0.
  - wraps<=wraps+1, holding at 2^WRAP_W-1 once reached.
  - Wraps in CHECK or ERROR are not counted and not pulsed.
- Latency: a count_in value sampled at edge k affects the outputs visible after edge k (one register stage).
- A stuck count_in (same value twice) counts as a mismatch.
- err_flag, err_cnt and last_err_val persist through re-lock; only rst or clr clears them.

Test Plan:
1. Reset with upstream: rst low 2 cycles, then upstream counts 15,14,13,12,... -> locked=0 after the edges sampling 15, 14 and 13; locked=1 after the edge sampling 12; err_flag=0.
2. Wrap: continue from test 1 through 1,0,15 -> wrap_pulse=1 for exactly one cycle after the edge sampling 15 (following 0); wraps=1; a second full period gives wraps=2.
3. Glitch while locked: drive 7,6,9 -> after the edge sampling 9: err_flag=1, err_cnt=1, last_err_val=9, locked=0. Then drive 8,7,6 -> locked=1 again after the edge sampling 6 (ERROR sets run=1 on 8, then 7 gives run=2, 6 gives run=3), with err_flag still 1.
4. Saturation: WRAP_W=2, run 5 clean wraps -> wraps goes 1,2,3,3,3 while wrap_pulse still fires each time. ERR_W=2 with 5 injected errors -> err_cnt goes 1,2,3,3,3.
5. clr mid-run: while LOCKED with wraps=5 and err_flag=1, assert clr for one cycle -> all outputs become 0; re-lock takes the same 4 samples as in test 1.
6. Priority and stuck input: rst=0 and clr=1 together give reset values. Holding count_in=4 for 2 cycles while LOCKED -> err_flag=1, last_err_val=4.
